// File: rtl/ifetch_stage.sv
// PC generation and fetch for the 64-word imem, with an IF/ID register.
// Redirect, stall and fetch faults are handled here; HALT exits only via reset.
package ifetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    F_NONE     = 2'b00,
    F_MISALIGN = 2'b01,
    F_RANGE    = 2'b10
  } fault_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        halted_o,
  output logic [1:0]  fault_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS);

  state_t      state;
  if_id_t      ifid;
  fault_t      fault;
  logic        halted;
  logic [31:0] pc;
  logic [31:0] cnt;

  logic [31:0] pc_next4;
  logic [31:0] tgt_pc;
  logic        oor;

  logic in_halt;
  logic do_mis;
  logic do_redir;
  logic do_stall;
  logic do_oor;
  logic do_fetch;

  assign pc_next4 = pc + 32'd4;
  assign tgt_pc   = {redirect_target_i[31:1], 1'b0};
  assign oor      = {2'b00, pc[31:2]} >= LIMIT;

  // Exactly one of these is set each cycle, in priority order.
  assign in_halt  = (state == HALT);
  assign do_mis   = !in_halt && redirect_i && redirect_target_i[1];
  assign do_redir = !in_halt && redirect_i && !redirect_target_i[1];
  assign do_stall = !in_halt && !redirect_i && stall_i;
  assign do_oor   = !in_halt && !redirect_i && !stall_i && oor;
  assign do_fetch = !in_halt && !redirect_i && !stall_i && !oor;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= RUN;
      pc            <= RESET_PC;
      ifid.instr    <= NOP_INSTR;
      ifid.pc       <= 32'd0;
      ifid.pc_plus4 <= 32'd0;
      ifid.valid    <= 1'b0;
      halted        <= 1'b0;
      fault         <= F_NONE;
      cnt           <= 32'd0;
    end else begin
      unique case (1'b1)
        in_halt: begin
          ifid.valid <= 1'b0;
          ifid.instr <= NOP_INSTR;
        end
        do_mis: begin
          state      <= HALT;
          halted     <= 1'b1;
          fault      <= F_MISALIGN;
          ifid.valid <= 1'b0;
          ifid.instr <= NOP_INSTR;
        end
        do_redir: begin
          pc         <= tgt_pc;
          ifid.valid <= 1'b0;
          ifid.instr <= NOP_INSTR;
        end
        do_stall: begin
        end
        do_oor: begin
          state      <= HALT;
          halted     <= 1'b1;
          fault      <= F_RANGE;
          ifid.valid <= 1'b0;
          ifid.instr <= NOP_INSTR;
        end
        do_fetch: begin
          ifid.instr    <= imem_rd;
          ifid.pc       <= pc;
          ifid.pc_plus4 <= pc_next4;
          ifid.valid    <= 1'b1;
          pc            <= pc_next4;
          cnt           <= cnt + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_a        = pc;
  assign instr_o       = ifid.instr;
  assign pc_o          = ifid.pc;
  assign pc_plus4_o    = ifid.pc_plus4;
  assign valid_o       = ifid.valid;
  assign halted_o      = halted;
  assign fault_o       = fault;
  assign fetch_count_o = cnt;

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- PC-generation and fetch stage directly upstream of the 64-word instruction memory (`imem`).
- Holds the program counter and drives the `imem` word address combinationally.
- Latches the returned instruction into an IF/ID output register with a valid bit.
- Supports stall and branch/jump redirect from downstream, and halts on fetch faults (misaligned target, address beyond memory).

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_WORDS, 64, number of 32-bit words in `imem`; fetches at or above IMEM_WORDS*4 fault.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in instr_o when valid_o=0.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- imem_a  output  32  byte address to `imem` port a; equals current PC combinationally.
- imem_rd  input  32  instruction word returned by `imem` (combinational read).
- stall_i  input  1  hold PC and IF/ID register.
- redirect_i  input  1  taken branch/JAL/JALR; load redirect_target_i.
- redirect_target_i  input  32  new PC; bit0 ignored (forced 0, JALR rule).
- instr_o  output  32  IF/ID instruction.
- pc_o  output  32  IF/ID PC of instr_o.
- pc_plus4_o  output  32  IF/ID pc_o+4 (link value).
- valid_o  output  1  instr_o is a real instruction.
- halted_o  output  1  stage in HALT state.
- fault_o  output  2  00 none, 01 misaligned redirect, 10 fetch out of range; sticky.
- fetch_count_o  output  32  number of instructions issued with valid_o=1; wraps modulo 2^32.

Behaviour:
- Reset (reset=0 at a rising edge), regardless of state or other inputs:
  - pc=RESET_PC, instr_o=NOP_INSTR, pc_o=0, pc_plus4_o=0, valid_o=0.
  - halted_o=0, fault_o=00, fetch_count_o=0, state=RUN.
- imem_a = pc at all times (no registered delay). `imem` word index is imem_a[31:2].
- States: RUN, HALT.
- RUN, priority per rising edge (highest first):
  1. redirect_i=1 and target[1]=1: enter HALT, fault_o=01. pc unchanged. IF/ID bubble (valid_o=0, instr_o=NOP_INSTR).
  2. redirect_i=1, aligned target: pc <= {target[31:1],1'b0}. IF/ID bubble, because the wrong-path fetch is squashed. Redirect overrides stall_i.
  3. stall_i=1: pc and all IF/ID outputs hold; fetch_count_o holds.
  4. pc[31:2] >= IMEM_WORDS: enter HALT, fault_o=10, IF/ID bubble, pc unchanged.
  5. Otherwise:
     - IF/ID <= {imem_rd, pc, pc+4, valid=1}.
     - pc <= pc+4, 32-bit wrap.
     - fetch_count_o += 1.
- HALT:
  - pc frozen; valid_o=0; instr_o=NOP_INSTR.
  - halted_o=1 (registered, asserted the cycle after entry).
  - fault_o holds its code.
  - stall_i and redirect_i are ignored.
  - Exits only via reset.
- Latency: an instruction at address A appears on instr_o one cycle after pc=A with no stall.
- pc_o/pc_plus4_o hold their last values during bubbles. Only valid_o and instr_o are forced.
- Arithmetic: pc+4 and the counter are unsigned 32-bit and wrap silently. RESET_PC is assumed word-aligned by the integrator; the misalignment check applies only to redirects.
- Reset mid-operation overrides stall, redirect and HALT in the same cycle.

Test Plan:
1. Reset then 5 free-running cycles with imem holding program words → instr_o sequence 00500113, 00C00193, FF718393, 0023E233.
   - pc_o = 0,4,8,C; valid_o=1 from cycle 2; fetch_count_o=4.
2. stall_i=1 for 3 cycles while pc=8 → instr_o stays 00C00193, imem_a stays 8, fetch_count_o frozen; on release, FF718393 appears next cycle.
3. redirect_i=1, target=0x30, with stall_i=1 in the same cycle → next cycle valid_o=0 and imem_a=0x30. Following cycle instr_o=RAM[12]=402383B3, pc_o=0x30.
4. Redirect target=0x21 → pc becomes 0x20 (bit0 cleared), no fault. Target=0x22 → halted_o=1, fault_o=01, valid_o=0 thereafter, pc stays unchanged.
5. Redirect to 0xFC, run 2 cycles → RAM[63] issued with pc_o=0xFC. Next fetch at 0x100 → fault_o=10, halted_o=1, fetch_count_o stops.
6. Assert reset=0 while HALT with stall_i=1 and redirect_i=1 → next cycle pc=RESET_PC, fault_o=00, halted_o=0, valid_o=0, fetch_count_o=0; fetch resumes from 0.
